// File: rtl/conv_out_sequencer.sv
// Output-stage sequencer for one conv layer: counts MAC beats, neurons, planes and
// channels, and issues delayed lane-packed buffer writes. Optional CONV_SEQ_PERF_CNT_EN adds a stall counter.
module conv_out_sequencer #(
  parameter int MAC_CNT    = 25,
  parameter int PLANE_SIZE = 784,
  parameter int NUM_OCH    = 8,
  parameter int PIPE_DLY   = 2,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mac_valid,
  output logic              busy,
  output logic              neuron_rdy,
  output logic              plane_rdy,
  output logic              layer_done,
  output logic              out_we,
  output logic [3:0]        out_wea,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        och_idx,
  output logic [31:0]       stall_cycles
);

  localparam int MC_W  = (MAC_CNT > 1) ? $clog2(MAC_CNT) : 1;
  localparam int PIX_W = (PLANE_SIZE > 1) ? $clog2(PLANE_SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [MC_W-1:0]   mac_cnt_q, mac_cnt_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [7:0]        ch_q, ch_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              neuron_rdy_q, plane_rdy_q;

  logic              beat, beat_last, pix_last, ch_last, pipe_busy;
  logic [ADDR_W-1:0] cur_addr;
  logic [3:0]        cur_lane;

  logic              vld_q  [PIPE_DLY];
  logic [ADDR_W-1:0] addr_q [PIPE_DLY];
  logic [3:0]        lane_q [PIPE_DLY];

  assign beat      = (state_q == S_RUN) && mac_valid;
  assign beat_last = beat && (mac_cnt_q == MC_W'(MAC_CNT - 1));
  assign pix_last  = (pix_q == PIX_W'(PLANE_SIZE - 1));
  assign ch_last   = (ch_q == 8'(NUM_OCH - 1));
  // base_q tracks (ch/4)*PLANE_SIZE incrementally, so no multiplier is needed.
  assign cur_addr  = base_q + ADDR_W'(pix_q);
  assign cur_lane  = 4'b0001 << ch_q[1:0];

  always_comb begin
    state_d   = state_q;
    mac_cnt_d = mac_cnt_q;
    pix_d     = pix_q;
    ch_d      = ch_q;
    base_d    = base_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          mac_cnt_d = '0;
          pix_d     = '0;
          ch_d      = '0;
          base_d    = '0;
        end
      end
      S_RUN: begin
        if (beat_last) begin
          mac_cnt_d = '0;
          if (pix_last) begin
            pix_d = '0;
            if (ch_last) begin
              state_d = S_DRAIN;
            end else begin
              ch_d = ch_q + 8'd1;
              if (ch_q[1:0] == 2'd3) base_d = base_q + ADDR_W'(PLANE_SIZE);
            end
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end else if (beat) begin
          mac_cnt_d = mac_cnt_q + MC_W'(1);
        end
      end
      S_DRAIN: begin
        if (!pipe_busy) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mac_cnt_q    <= '0;
      pix_q        <= '0;
      ch_q         <= '0;
      base_q       <= '0;
      neuron_rdy_q <= 1'b0;
      plane_rdy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mac_cnt_q    <= mac_cnt_d;
      pix_q        <= pix_d;
      ch_q         <= ch_d;
      base_q       <= base_d;
      neuron_rdy_q <= beat_last;
      plane_rdy_q  <= beat_last && pix_last;
    end
  end

  // Address/lane stages only advance with a valid entry, so the last stage holds
  // the most recent write address while out_we is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q[0]  <= 1'b0;
      addr_q[0] <= '0;
      lane_q[0] <= '0;
    end else begin
      vld_q[0] <= beat_last;
      if (beat_last) begin
        addr_q[0] <= cur_addr;
        lane_q[0] <= cur_lane;
      end
    end
  end

  generate
    for (genvar gi = 1; gi < PIPE_DLY; gi++) begin : g_pipe
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q[gi]  <= 1'b0;
          addr_q[gi] <= '0;
          lane_q[gi] <= '0;
        end else begin
          vld_q[gi] <= vld_q[gi-1];
          if (vld_q[gi-1]) begin
            addr_q[gi] <= addr_q[gi-1];
            lane_q[gi] <= lane_q[gi-1];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k < PIPE_DLY; k++) pipe_busy = pipe_busy | vld_q[k];
  end

  assign busy       = (state_q != S_IDLE);
  assign layer_done = (state_q == S_DONE);
  assign neuron_rdy = neuron_rdy_q;
  assign plane_rdy  = plane_rdy_q;
  assign och_idx    = ch_q;
  assign out_we     = vld_q[PIPE_DLY-1];
  assign out_addr   = addr_q[PIPE_DLY-1];
  assign out_wea    = vld_q[PIPE_DLY-1] ? lane_q[PIPE_DLY-1] : 4'b0000;

`ifdef CONV_SEQ_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_q <= '0;
    end else if (state_q == S_RUN && !mac_valid && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/conv_out_sequencer.md
Name: conv_out_sequencer

Overview:
- Synchronous sequencer for one conv layer's output stage.
- Counts MAC beats per neuron, neurons per plane and planes per layer.
- Issues delayed, packed writes to the output buffer: 4 output channels share one word; the lane is selected by channel mod 4.
- Sits between the MAC datapath and the output BRAM. Replaces the ad-hoc edge-triggered ready/address logic with one clocked FSM.

Parameters:
- MAC_CNT, 25: mac_valid beats per neuron ((in_ch/4+1)*5*5). Must be >=1.
- PLANE_SIZE, 784: neurons per output plane (R*C). Must be >=1.
- NUM_OCH, 8: output channels per layer. Multiple of 4, >=4.
- PIPE_DLY, 2: cycles from the last MAC beat to the result being valid at the buffer. Range 1..8.
- ADDR_W, 16: output address width. Must hold (NUM_OCH/4)*PLANE_SIZE-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a layer when idle
- mac_valid  in  1  datapath performed one MAC beat this cycle
- busy  out  1  high from the cycle after an accepted start until layer_done
- neuron_rdy  out  1  one-cycle pulse: neuron accumulation complete
- plane_rdy  out  1  one-cycle pulse: last neuron of a plane complete
- layer_done  out  1  one-cycle pulse: all writes retired
- out_we  out  1  output buffer write strobe
- out_wea  out  4  one-hot byte-lane enable (ch%4); 0 when out_we=0
- out_addr  out  ADDR_W  write address = (ch/4)*PLANE_SIZE + pix
- och_idx  out  8  current output channel
- stall_cycles  out  32  RUN cycles with mac_valid=0 (see Optional Feature)

Behaviour:
- Reset:
  - Asynchronous assert, synchronous deassert assumed by the system.
  - All outputs 0, state IDLE, counters mac_cnt, pix, ch = 0, write pipe cleared.
  - Reset mid-layer aborts immediately. No layer_done is produced and no further writes occur.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> RUN. Counters are cleared on entry.
  - RUN: see counting rules below.
  - DRAIN: wait until the write pipe is empty -> DONE.
  - DONE: layer_done=1 for exactly one cycle -> IDLE.
  - start outside IDLE is ignored.
- RUN counting:
  - mac_valid is counted only in RUN; it is ignored in all other states.
  - Let T be the cycle with mac_valid=1 and mac_cnt==MAC_CNT-1. At T, mac_cnt wraps to 0.
  - neuron_rdy=1 at T+1.
  - If pix==PLANE_SIZE-1 at T: plane_rdy=1 at T+1, pix wraps to 0 and ch increments. Otherwise pix increments.
  - If also ch==NUM_OCH-1 at T: the FSM enters DRAIN at T+1 instead of wrapping ch.
- Write pipe:
  - A PIPE_DLY-deep shift register of {valid, addr, lane}, loaded at T with the pre-increment pix/ch.
  - out_we, out_addr and out_wea are asserted at cycle T+PIPE_DLY for one cycle.
  - out_addr uses the pre-increment values: ch for the (ch/4) term and pix for the pixel term.
  - Address arithmetic: group*PLANE_SIZE computed at ADDR_W width, no truncation allowed by parameter rule.
  - Back-to-back neurons (MAC_CNT=1) produce a write every cycle, with no loss.
- Boundaries:
  - Plane boundary: the address jumps from (g*PLANE_SIZE + PLANE_SIZE-1) to the next channel's base. When ch%4 != 3, the next base is the same group base with a new lane.
  - The last write of the layer must retire before layer_done. layer_done occurs at cycle T+PIPE_DLY+1 or later, never earlier.
  - out_addr holds its last value when out_we=0.
  - och_idx reflects ch; it is reset to 0 at start.

Optional Feature:
- Macro: CONV_SEQ_PERF_CNT_EN.
- Defined:
  - stall_cycles increments each RUN cycle with mac_valid=0.
  - It is cleared on accepted start and by reset, and saturates at 2^32-1.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesized.

Test Plan:
- Basic layer (MAC_CNT=3, PLANE_SIZE=4, NUM_OCH=8, PIPE_DLY=2), start, then mac_valid=1 continuously:
  - 32 writes. Addresses 0,1,2,3 four times with out_wea 0001, 0010, 0100, 1000, then 4..7 with the same lane sequence.
  - neuron_rdy 32 pulses, plane_rdy 8 pulses, then layer_done once, then busy=0.
- Same config, mac_valid toggled 1,0,1,0:
  - Identical write sequence.
  - Each write occurs 2 cycles after its 3rd counted beat.
  - stall_cycles equals the number of zero cycles in RUN (macro defined), or 0 (macro undefined).
- MAC_CNT=1, PIPE_DLY=1:
  - out_we is high on consecutive cycles, with addresses incrementing by 1.
  - No write is dropped at the plane boundary (addr 3 -> 0 with lane 0001 -> 0010).
- start pulsed again while busy:
  - Ignored; counters are unaffected and the write count stays at 32.
- rst_n asserted after the 10th write:
  - All outputs go to 0 at once; no further out_we and no layer_done.
  - A new start then restarts at addr 0, lane 0001.
